// File: rtl/morse_decoder.sv
// Morse receiver: times marks and spaces on a keyed input and emits ASCII characters.
module morse_decoder #(
    parameter int unsigned UNIT_CYCLES     = 2500000,
    parameter int unsigned MIN_MARK_CYCLES = 312500,
    parameter int unsigned CNT_W           = 32
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iKEY,
    output logic [7:0] oCHAR,
    output logic       oVALID,
    output logic       oERR
);

    localparam logic [CNT_W-1:0] MIN_LIM  = CNT_W'(MIN_MARK_CYCLES);
    localparam logic [CNT_W-1:0] DOT_LIM  = CNT_W'(2 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] WORD_LIM = CNT_W'(5 * UNIT_CYCLES);
    localparam logic [7:0]       CH_ERR   = 8'h3F;
    localparam logic [7:0]       CH_SPACE = 8'h20;

    typedef enum logic [1:0] {S_IDLE, S_MARK, S_SPACE, S_GAP} state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             key_s_q, key_s_d;
    logic             key_prev_q, key_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       pat_q, pat_d;
    logic [2:0]       len_q, len_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       char_q, char_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic             rise;
    logic             fall;
    logic [7:0]       dec_char;
    logic             dec_known;

    assign rise   = key_s_q & ~key_prev_q;
    assign fall   = ~key_s_q & key_prev_q;
    assign oCHAR  = char_q;
    assign oVALID = valid_q;
    assign oERR   = err_q;

    // ITU table lookup on {length, elements}; first element sits at bit len-1
    always_comb begin
        dec_char  = CH_ERR;
        dec_known = 1'b1;
        case ({len_q, pat_q})
            8'b001_00000: dec_char = 8'h45; // E
            8'b001_00001: dec_char = 8'h54; // T
            8'b010_00000: dec_char = 8'h49; // I
            8'b010_00001: dec_char = 8'h41; // A
            8'b010_00010: dec_char = 8'h4E; // N
            8'b010_00011: dec_char = 8'h4D; // M
            8'b011_00000: dec_char = 8'h53; // S
            8'b011_00001: dec_char = 8'h55; // U
            8'b011_00010: dec_char = 8'h52; // R
            8'b011_00011: dec_char = 8'h57; // W
            8'b011_00100: dec_char = 8'h44; // D
            8'b011_00101: dec_char = 8'h4B; // K
            8'b011_00110: dec_char = 8'h47; // G
            8'b011_00111: dec_char = 8'h4F; // O
            8'b100_00000: dec_char = 8'h48; // H
            8'b100_00001: dec_char = 8'h56; // V
            8'b100_00010: dec_char = 8'h46; // F
            8'b100_00100: dec_char = 8'h4C; // L
            8'b100_00110: dec_char = 8'h50; // P
            8'b100_00111: dec_char = 8'h4A; // J
            8'b100_01000: dec_char = 8'h42; // B
            8'b100_01001: dec_char = 8'h58; // X
            8'b100_01010: dec_char = 8'h43; // C
            8'b100_01011: dec_char = 8'h59; // Y
            8'b100_01100: dec_char = 8'h5A; // Z
            8'b100_01101: dec_char = 8'h51; // Q
            8'b101_00000: dec_char = 8'h35; // 5
            8'b101_00001: dec_char = 8'h34; // 4
            8'b101_00011: dec_char = 8'h33; // 3
            8'b101_00111: dec_char = 8'h32; // 2
            8'b101_01111: dec_char = 8'h31; // 1
            8'b101_11111: dec_char = 8'h30; // 0
            8'b101_10000: dec_char = 8'h36; // 6
            8'b101_11000: dec_char = 8'h37; // 7
            8'b101_11100: dec_char = 8'h38; // 8
            8'b101_11110: dec_char = 8'h39; // 9
            default:      dec_known = 1'b0;
        endcase
    end

    // Next-state: synchronizer, mark/space timing, element capture and emission
    always_comb begin
        state_d    = state_q;
        sync1_d    = iKEY;
        key_s_d    = sync1_q;
        key_prev_d = key_s_q;
        pat_d      = pat_q;
        len_d      = len_q;
        ovf_d      = ovf_q;
        char_d     = char_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_MARK;
                    pat_d   = 5'd0;
                    len_d   = 3'd0;
                    ovf_d   = 1'b0;
                end
            end
            S_MARK: begin
                if (fall) begin
                    if (cnt_q < MIN_LIM) begin
                        // too short to be an element: drop it, keep what we had
                        state_d = (len_q != 3'd0) ? S_SPACE : S_IDLE;
                    end else begin
                        if (len_q == 3'd5) begin
                            ovf_d = 1'b1;
                        end else begin
                            pat_d = {pat_q[3:0], (cnt_q >= DOT_LIM)};
                            len_d = len_q + 3'd1;
                        end
                        state_d = S_SPACE;
                    end
                end
            end
            S_SPACE: begin
                if (rise) begin
                    state_d = S_MARK;
                end else if (cnt_q >= DOT_LIM) begin
                    valid_d = 1'b1;
                    err_d   = ovf_q | ~dec_known;
                    char_d  = (ovf_q | ~dec_known) ? CH_ERR : dec_char;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (rise) begin
                    state_d = S_MARK;
                    pat_d   = 5'd0;
                    len_d   = 3'd0;
                    ovf_d   = 1'b0;
                end else if (cnt_q >= WORD_LIM) begin
                    valid_d = 1'b1;
                    char_d  = CH_SPACE;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // duration counter restarts on any key edge or state change, saturates at 5 units
        if (rise || fall || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (cnt_q < WORD_LIM) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // All state and output registers with synchronous reset
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q    <= S_IDLE;
            sync1_q    <= 1'b0;
            key_s_q    <= 1'b0;
            key_prev_q <= 1'b0;
            cnt_q      <= '0;
            pat_q      <= 5'd0;
            len_q      <= 3'd0;
            ovf_q      <= 1'b0;
            char_q     <= 8'h00;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            key_s_q    <= key_s_d;
            key_prev_q <= key_prev_d;
            cnt_q      <= cnt_d;
            pat_q      <= pat_d;
            len_q      <= len_d;
            ovf_q      <= ovf_d;
            char_q     <= char_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_morse_decoder.sv
// Scoreboard bench for morse_decoder with 10-cycle units.
module tb_morse_decoder;

    logic       clk;
    logic       rst;
    logic       key;
    logic [7:0] ochar;
    logic       ovalid;
    logic       oerr;

    int unsigned n_vec;
    int unsigned n_err;
    logic [8:0]  exp_q[$];

    morse_decoder #(
        .UNIT_CYCLES    (10),
        .MIN_MARK_CYCLES(2),
        .CNT_W          (32)
    ) dut (
        .iCLK  (clk),
        .iRST  (rst),
        .iKEY  (key),
        .oCHAR (ochar),
        .oVALID(ovalid),
        .oERR  (oerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void expect_char(input logic [7:0] c, input logic e);
        exp_q.push_back({e, c});
    endfunction

    // Compare every strobe against the head of the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (ovalid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_strobe", 32'(ovalid), 32'd0);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("char", 32'(ochar), 32'(e[7:0]));
                    check("err", 32'(oerr), 32'(e[8]));
                end
            end else if (oerr) begin
                check("stray_err", 32'(oerr), 32'd0);
            end
        end
    end

    task automatic key_drive(input logic v, input int n);
        key = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_pattern(input string p, input int gap);
        for (int i = 0; i < p.len(); i++) begin
            key_drive(1'b1, (p[i] == 8'h2D) ? 30 : 10);
            key_drive(1'b0, (i == p.len() - 1) ? gap : 10);
        end
    endtask

    task automatic drain(input string tag);
        key_drive(1'b0, 120);
        check(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        key   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_char", 32'(ochar), 32'h00);
        check("rst_valid", 32'(ovalid), 32'd0);
        check("rst_err", 32'(oerr), 32'd0);
        rst = 1'b0;
        key_drive(1'b0, 5);

        // single dot then word gap
        expect_char(8'h45, 1'b0);
        expect_char(8'h20, 1'b0);
        send_pattern(".", 80);
        drain("e_done");
        check("char_hold", 32'(ochar), 32'h20);

        // SOS with letter gaps
        expect_char(8'h53, 1'b0);
        expect_char(8'h4F, 1'b0);
        expect_char(8'h53, 1'b0);
        expect_char(8'h20, 1'b0);
        send_pattern("...", 30);
        send_pattern("---", 30);
        send_pattern("...", 70);
        drain("sos_done");

        // five dots, six dots (overflow), six-element unknown
        expect_char(8'h35, 1'b0);
        expect_char(8'h20, 1'b0);
        send_pattern(".....", 80);
        drain("five_done");
        expect_char(8'h3F, 1'b1);
        expect_char(8'h20, 1'b0);
        send_pattern("......", 80);
        drain("six_done");
        expect_char(8'h3F, 1'b1);
        expect_char(8'h20, 1'b0);
        send_pattern("--...-", 80);
        drain("ovf_done");

        // glitch inside the space after a dot
        expect_char(8'h45, 1'b0);
        expect_char(8'h20, 1'b0);
        send_pattern(".", 5);
        key_drive(1'b1, 1);
        key_drive(1'b0, 80);
        drain("glitch_done");

        // reset mid-character discards the two dashes
        send_pattern("--", 5);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", 32'(ovalid), 32'd0);
        check("rst_mid_char", 32'(ochar), 32'h00);
        rst = 1'b0;
        expect_char(8'h45, 1'b0);
        expect_char(8'h20, 1'b0);
        send_pattern(".", 30);
        drain("rst_done");

        // long hold saturates into a dash
        expect_char(8'h54, 1'b0);
        expect_char(8'h20, 1'b0);
        key_drive(1'b1, 1000);
        key_drive(1'b0, 80);
        drain("hold_done");
        check("t_space_hold", 32'(ochar), 32'h20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/morse_decoder.md
Name: morse_decoder

Overview:
- Receive-side counterpart of the `morse` tone generator.
- Takes an on/off keyed Morse signal, such as a key or a demodulated `oSOUND` envelope, and times its marks and spaces in units of `UNIT_CYCLES`.
- Decodes letters A–Z and digits 0–9 into ASCII, emitting a one-cycle valid strobe per character, including a space character at word gaps.
- Sits between a keyed input and a character consumer such as a UART TX or display.

Parameters:
- UNIT_CYCLES, 2500000, clock cycles per Morse time unit (one dot); the bench uses 10.
- MIN_MARK_CYCLES, 312500, marks shorter than this are glitches and are discarded; the bench uses 2.
- CNT_W, 32, width of the duration counter; must hold 5*UNIT_CYCLES.

Ports:
- iCLK  input  1  system clock
- iRST  input  1  synchronous, active-high reset
- iKEY  input  1  keyed Morse input, 1 = mark (tone on), asynchronous to iCLK
- oCHAR  output  8  ASCII of the decoded character; held until the next strobe
- oVALID  output  1  one-cycle strobe, oCHAR valid
- oERR  output  1  high with oVALID when oCHAR = 0x3F ('?') due to unknown or overlong pattern

Behaviour:
- Reset (iRST sampled high on a rising iCLK edge):
  - oCHAR = 0x00, oVALID = 0, oERR = 0.
  - State = IDLE; pattern, length, counter and overflow flag cleared.
  - Synchronizer flops cleared to 0.
  - Reset mid-character discards all partial elements.
- Input path: iKEY passes through a 2-flop synchronizer to key_s. Edges are detected on key_s versus its previous value. Total input latency is 3 cycles.
- Counter cnt:
  - Cleared to 0 on every key_s edge and on every state change.
  - Otherwise increments each cycle, saturating at 5*UNIT_CYCLES.
- Element storage:
  - pat[4:0] is a shift register; 0 = dot, 1 = dash; the first element ends in the MSB of the used length.
  - len[2:0] counts elements, 0..5.
  - ovf is set if a sixth element arrives; further elements are ignored.
- State machine:
  - IDLE: key_s rise -> MARK.
  - MARK, on key_s fall:
    - If cnt < MIN_MARK_CYCLES, the glitch is discarded: go to SPACE if len > 0, else IDLE.
    - Otherwise append dot if cnt < 2*UNIT_CYCLES, else dash; len++ (or set ovf if len = 5); go to SPACE.
    - Key held indefinitely: cnt saturates and the mark is a dash on release.
  - SPACE:
    - key_s rise -> MARK.
    - When cnt reaches 2*UNIT_CYCLES, emit the character (oVALID=1 next cycle), then go to GAP.
  - GAP:
    - key_s rise -> MARK with pat/len/ovf cleared.
    - When cnt reaches 5*UNIT_CYCLES (counted from GAP entry, i.e. 7 units total space), emit 0x20, then go to IDLE.
  - Simultaneous key_s rise and a threshold hit in the same cycle: the rise wins, no emission.
- Decode: lookup on {len, pat} covering standard ITU A–Z (0x41–0x5A) and 0–9 (0x30–0x39).
  - Any other pattern, or ovf=1, -> oCHAR=0x3F, oERR=1.
- oVALID is high for exactly one cycle per emission. oERR is high only in that same cycle. oCHAR is registered and keeps its value afterwards.
- A glitch during SPACE restarts space timing (cnt cleared on its edges) and does not alter pat/len.

Test Plan (UNIT_CYCLES=10, MIN_MARK_CYCLES=2):
1. Reset, then mark 10 cycles, then key low 80 cycles -> oVALID pulse with oCHAR=0x45 ('E'), oERR=0, then a second pulse with oCHAR=0x20. Exactly 2 pulses.
2. "SOS": dots/dashes of 10/30 cycles, 10-cycle intra gaps, 30-cycle letter gaps -> oCHAR 0x53, 0x4F, 0x53 in order, no space until the final 70-cycle gap.
3. Five dots -> 0x35 ('5'). Six dots -> 0x3F with oERR=1. Pattern dash-dash-dot-dot-dot-dash (6 elements) -> 0x3F, oERR=1.
4. Dot, then a 1-cycle iKEY pulse 5 cycles into the space, then silence -> single 'E' (0x45); glitch ignored.
5. Two dashes, then iRST high for 1 cycle, then dot and 30-cycle gap -> 0x45 ('E'), not 'G'. During reset oVALID=0 and oCHAR=0x00.
6. iKEY held high 1000 cycles, then released -> counter saturates without wrap, decoded 'T' (0x54).
